// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : MEM-stage data-memory access controller. Converts MemRead /
//               MemWrite from EX/MEM into a req/ack transaction on a
//               variable-latency data memory. While the access is in flight
//               it stalls the upstream pipeline and gates RegWrite so MEM/WB
//               captures a bubble. Load data is registered on ReadData_o.
//               Optional build macro DMEM_TIMEOUT_EN adds a REQ-state watchdog
//               that aborts an access after TIMEOUT_CYC cycles without ack.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegWrite_i,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] WriteData_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] ReadData_o,
    output logic              RegWrite_o,
    output logic              stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] c_ABORT_DATA = DATA_W'(32'hDEADBEEF);

    state_t              r_state_q, w_state_d;
    logic                r_req_q,   w_req_d;
    logic                r_we_q,    w_we_d;
    logic [ADDR_W-1:0]   r_addr_q,  w_addr_d;
    logic [DATA_W-1:0]   r_wdata_q, w_wdata_d;
    logic [DATA_W-1:0]   r_rdata_q, w_rdata_d;
    logic                r_err_q,   w_err_d;

    logic                w_rw;
    logic                w_aligned;
    logic                w_acc;
    logic                w_stall;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0]    r_cnt_q,   w_cnt_d;
`else
    // The watchdog depth only matters when the timeout is built in.
    logic                w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // Decode the MEM-stage instruction: only word-aligned accesses go to memory.
    always_comb begin
        w_rw      = MemRead_i | MemWrite_i;
        w_aligned = (Addr_i[1:0] == 2'b00);
        w_acc     = w_rw & w_aligned;
    end

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        w_state_d = r_state_q;
        w_req_d   = r_req_q;
        w_we_d    = r_we_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_rdata_d = r_rdata_q;
        w_err_d   = r_err_q;
`ifdef DMEM_TIMEOUT_EN
        w_cnt_d   = r_cnt_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                // Misaligned accesses pass through without touching memory.
                if (w_rw && !w_aligned) begin
                    w_err_d = 1'b1;
                end
                if (w_acc) begin
                    w_addr_d  = Addr_i;
                    w_wdata_d = WriteData_i;
                    // A read+write conflict is executed as a write and flagged.
                    w_we_d    = MemWrite_i;
                    w_req_d   = 1'b1;
                    w_state_d = ST_REQ;
                    if (MemRead_i && MemWrite_i) begin
                        w_err_d = 1'b1;
                    end
`ifdef DMEM_TIMEOUT_EN
                    w_cnt_d = '0;
`endif
                end
            end
            ST_REQ: begin
                // An ack always wins over a simultaneous watchdog expiry.
                if (mem_ack_i) begin
                    w_req_d   = 1'b0;
                    if (!r_we_q) begin
                        w_rdata_d = mem_rdata_i;
                    end
                    w_state_d = ST_DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (r_cnt_q == c_CNT_LAST) begin
                    w_req_d   = 1'b0;
                    w_err_d   = 1'b1;
                    if (!r_we_q) begin
                        w_rdata_d = c_ABORT_DATA;
                    end
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                // EX/MEM still holds the finished instruction here, so never
                // re-evaluate it; just return to IDLE.
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_req_d   = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any in-flight access.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_state_q <= ST_IDLE;
            r_req_q   <= 1'b0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_rdata_q <= '0;
            r_err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            r_cnt_q   <= '0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_req_q   <= w_req_d;
            r_we_q    <= w_we_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_rdata_q <= w_rdata_d;
            r_err_q   <= w_err_d;
`ifdef DMEM_TIMEOUT_EN
            r_cnt_q   <= w_cnt_d;
`endif
        end
    end

    // Stall covers the issuing IDLE cycle plus every REQ cycle; the reset
    // term keeps the pipeline-facing controls quiet while start_i is low.
    always_comb begin
        w_stall = 1'b0;
        if (r_state_q == ST_IDLE) begin
            w_stall = w_acc;
        end else if (r_state_q == ST_REQ) begin
            w_stall = 1'b1;
        end
        w_stall = w_stall & start_i;
    end

    assign stall_o     = w_stall;
    assign RegWrite_o  = RegWrite_i & ~w_stall & start_i;
    assign mem_req_o   = r_req_q;
    assign mem_we_o    = r_we_q;
    assign mem_addr_o  = r_addr_q;
    assign mem_wdata_o = r_wdata_q;
    assign ReadData_o  = r_rdata_q;
    assign err_o       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Directed, self-checking bench for dmem_access_ctrl. Expected
//               memory requests and load results are queued when stimulus is
//               driven and popped when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk_i       = 1'b0;
    logic          start_i     = 1'b0;
    logic          MemRead_i   = 1'b0;
    logic          MemWrite_i  = 1'b0;
    logic          RegWrite_i  = 1'b0;
    logic [AW-1:0] Addr_i      = '0;
    logic [DW-1:0] WriteData_i = '0;
    logic          mem_ack_i   = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] ReadData_o;
    logic          RegWrite_o;
    logic          stall_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    dmem_access_ctrl #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .RegWrite_i  (RegWrite_i),
        .Addr_i      (Addr_i),
        .WriteData_i (WriteData_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .ReadData_o  (ReadData_o),
        .RegWrite_o  (RegWrite_o),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    req_t          req_q[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] model_rdata = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        RegWrite_i  = 1'b0;
        Addr_i      = '0;
        WriteData_i = '0;
    endtask

    // Present one instruction in IDLE, answer the request after ack_delay REQ
    // cycles, and check the whole stall / request / DONE sequence.
    task automatic do_access(input logic rd, input logic wr, input logic regw,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int ack_delay);
        req_t r;
        req_t got;
        int   stalls;
        r.we    = wr;
        r.addr  = addr;
        r.wdata = wdata;
        req_q.push_back(r);
        if (rd && !wr) model_rdata = rdata;
        rd_q.push_back(model_rdata);

        MemRead_i   = rd;
        MemWrite_i  = wr;
        RegWrite_i  = regw;
        Addr_i      = addr;
        WriteData_i = wdata;
        stalls      = 0;

        @(negedge clk_i);
        check("idle_stall", stall_o, 1);
        check("idle_regwrite", RegWrite_o, 0);
        check("idle_req", mem_req_o, 0);
        if (stall_o) stalls++;
        @(posedge clk_i); #1;

        got = req_q.pop_front();
        check("req_addr", mem_addr_o, got.addr);
        check("req_we", mem_we_o, got.we);
        check("req_wdata", mem_wdata_o, got.wdata);
        for (int k = 1; k <= ack_delay; k++) begin
            mem_ack_i   = (k == ack_delay);
            mem_rdata_i = (k == ack_delay) ? rdata : (32'h0BAD0000 + k);
            @(negedge clk_i);
            check("req_stall", stall_o, 1);
            check("req_regwrite", RegWrite_o, 0);
            check("req_high", mem_req_o, 1);
            check("req_addr_hold", mem_addr_o, got.addr);
            if (stall_o) stalls++;
            @(posedge clk_i); #1;
        end
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hFFFF_FFFF;

        @(negedge clk_i);
        check("done_stall", stall_o, 0);
        check("done_regwrite", RegWrite_o, regw);
        check("done_req", mem_req_o, 0);
        check("done_rdata", ReadData_o, rd_q.pop_front());
        check("stall_cycles", stalls, 1 + ack_delay);
        @(posedge clk_i); #1;
        clear_inputs();
    endtask

    initial begin
        // Reset asserted: pipeline-facing controls forced low even with a load presented.
        MemRead_i  = 1'b1;
        RegWrite_i = 1'b1;
        Addr_i     = 32'h10;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall", stall_o, 0);
        check("rst_regwrite", RegWrite_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_rdata", ReadData_o, 0);
        check("rst_err", err_o, 0);
        clear_inputs();
        start_i = 1'b1;
        @(posedge clk_i); #1;

        // Reset in the middle of REQ clears everything immediately.
        MemRead_i  = 1'b1;
        RegWrite_i = 1'b1;
        Addr_i     = 32'h40;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("midreq_req", mem_req_o, 1);
        #2 start_i = 1'b0;
        #1;
        check("midrst_req", mem_req_o, 0);
        check("midrst_addr", mem_addr_o, 0);
        check("midrst_we", mem_we_o, 0);
        check("midrst_stall", stall_o, 0);
        check("midrst_regwrite", RegWrite_o, 0);
        clear_inputs();
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555_5555;
        @(negedge clk_i);
        check("stray_req", mem_req_o, 0);
        check("stray_stall", stall_o, 0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("stray_rdata", ReadData_o, 0);
        check("stray_stall2", stall_o, 0);
        @(posedge clk_i); #1;

        // Load with ack in the first REQ cycle.
        do_access(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 32'h1234_5678, 1);
        // Store with ack after 5 REQ cycles; ReadData_o must keep the load value.
        do_access(1'b0, 1'b1, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0, 5);
        // Back-to-back loads.
        do_access(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'hA5A5_0001, 1);
        do_access(1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'h5A5A_0004, 1);
        @(negedge clk_i);
        check("b2b_no_dup_req", mem_req_o, 0);
        check("err_clean", err_o, 0);
        @(posedge clk_i); #1;

        // Read and write together: executed as a write, error flagged.
        do_access(1'b1, 1'b1, 1'b1, 32'h30, 32'h1111_2222, 32'h9999_9999, 2);
        @(negedge clk_i);
        check("rw_conflict_err", err_o, 1);

        // Reset clears the sticky error and the load register.
        start_i = 1'b0;
        model_rdata = '0;
        #1;
        check("rst2_err", err_o, 0);
        check("rst2_rdata", ReadData_o, 0);
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i); #1;

        // Misaligned load: no request, no stall, sticky error.
        MemRead_i  = 1'b1;
        RegWrite_i = 1'b1;
        Addr_i     = 32'h13;
        @(negedge clk_i);
        check("mis_stall", stall_o, 0);
        check("mis_req", mem_req_o, 0);
        check("mis_regwrite", RegWrite_o, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            check("mis_err", err_o, 1);
            check("mis_req_hold", mem_req_o, 0);
            check("mis_rdata", ReadData_o, 0);
        end
        clear_inputs();
        @(posedge clk_i); #1;
        do_access(1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 32'h0000_BEEF, 3);
        @(negedge clk_i);
        check("err_sticky", err_o, 1);
        @(posedge clk_i); #1;

`ifdef DMEM_TIMEOUT_EN
        // Watchdog: a load never acknowledged is aborted after TO REQ cycles.
        start_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        MemRead_i  = 1'b1;
        RegWrite_i = 1'b1;
        Addr_i     = 32'h50;
        @(posedge clk_i); #1;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk_i);
            check("to_req", mem_req_o, 1);
            check("to_stall", stall_o, 1);
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        check("to_req_drop", mem_req_o, 0);
        check("to_stall_rel", stall_o, 0);
        check("to_rdata", ReadData_o, 32'hDEAD_BEEF);
        check("to_err", err_o, 1);
        @(posedge clk_i); #1;
        clear_inputs();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
